// File: rtl/cond_flag_unit.sv
// -----------------------------------------------------------------------------
// cond_flag_unit
//
// Consumer end of the ALU flag interface. Holds the architectural NZCV flag
// register and evaluates each instruction's 4-bit condition field against it.
// The condition result gates the PC/register/memory write controls, which are
// presented through a one-deep registered valid/ready stage.
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   in_valid    instruction control bundle valid
//   in_ready    stage can accept the bundle this cycle
//   Cond        condition field
//   ALUFlags    {N,Z,C,V} produced by the ALU for this instruction
//   FlagW       [1] write N,Z ; [0] write C,V
//   PCS         instruction writes PC
//   RegW        instruction writes the register file
//   MemW        instruction writes memory
//   NoWrite     compare-type instruction, suppresses RegWrite
//   out_valid   registered bundle valid
//   out_ready   downstream accepts the bundle
//   PCSrc       gated PC write
//   RegWrite    gated register write
//   MemWrite    gated memory write
//   CondEx      registered condition result for the held bundle
//   Flags       current flag register {N,Z,C,V}
//   squash_cnt  saturating count of accepted bundles whose condition failed
// -----------------------------------------------------------------------------
module cond_flag_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] squash_cnt
);

  // Condition field decode against a {N,Z,C,V} flag vector.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flg);
    logic n;
    logic z;
    logic c;
    logic v;
    logic r;
    n = flg[3];
    z = flg[2];
    c = flg[1];
    v = flg[0];
    case (cond)
      4'h0:    r = z;
      4'h1:    r = ~z;
      4'h2:    r = c;
      4'h3:    r = ~c;
      4'h4:    r = n;
      4'h5:    r = ~n;
      4'h6:    r = v;
      4'h7:    r = ~v;
      4'h8:    r = c & ~z;
      4'h9:    r = ~c | z;
      4'hA:    r = (n == v);
      4'hB:    r = (n != v);
      4'hC:    r = ~z & (n == v);
      4'hD:    r = z | (n != v);
      4'hE:    r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             out_valid_r;
  logic             pcsrc_r;
  logic             regwrite_r;
  logic             memwrite_r;
  logic             condex_r;
  logic [3:0]       flags_r;
  logic [CNT_W-1:0] squash_r;

  logic             in_ready_s;
  logic             accept_s;
  logic             ce_s;
  logic [3:0]       flags_nxt_s;
  logic [CNT_W-1:0] squash_nxt_s;

  // Handshake, condition evaluation and next flag/counter values.
  always_comb begin
    in_ready_s   = ~out_valid_r | out_ready;
    accept_s     = in_valid & in_ready_s;
    // Evaluated against the flags as they stand before this instruction.
    ce_s         = cond_eval(Cond, flags_r);
    flags_nxt_s  = flags_r;
    squash_nxt_s = squash_r;
    if (accept_s) begin
      if (ce_s) begin
        if (FlagW[1]) begin
          flags_nxt_s[3:2] = ALUFlags[3:2];
        end else begin
          flags_nxt_s[3:2] = flags_r[3:2];
        end
        if (FlagW[0]) begin
          flags_nxt_s[1:0] = ALUFlags[1:0];
        end else begin
          flags_nxt_s[1:0] = flags_r[1:0];
        end
      end else begin
        if (squash_r != CNT_MAX) begin
          squash_nxt_s = squash_r + CNT_ONE;
        end else begin
          squash_nxt_s = squash_r;
        end
      end
    end else begin
      flags_nxt_s  = flags_r;
      squash_nxt_s = squash_r;
    end
  end

  // Output stage register: load on accept, drain when downstream takes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r <= 1'b0;
      pcsrc_r     <= 1'b0;
      regwrite_r  <= 1'b0;
      memwrite_r  <= 1'b0;
      condex_r    <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      condex_r    <= ce_s;
      pcsrc_r     <= PCS & ce_s;
      regwrite_r  <= RegW & ce_s & ~NoWrite;
      memwrite_r  <= MemW & ce_s;
    end else if (out_ready) begin
      // Gated controls are cleared with valid so an empty stage never
      // presents a write strobe.
      out_valid_r <= 1'b0;
      pcsrc_r     <= 1'b0;
      regwrite_r  <= 1'b0;
      memwrite_r  <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
      pcsrc_r     <= pcsrc_r;
      regwrite_r  <= regwrite_r;
      memwrite_r  <= memwrite_r;
      condex_r    <= condex_r;
    end
  end

  // Architectural flag register and squash counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_r  <= 4'b0000;
      squash_r <= {CNT_W{1'b0}};
    end else begin
      flags_r  <= flags_nxt_s;
      squash_r <= squash_nxt_s;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_r;
  assign PCSrc      = pcsrc_r;
  assign RegWrite   = regwrite_r;
  assign MemWrite   = memwrite_r;
  assign CondEx     = condex_r;
  assign Flags      = flags_r;
  assign squash_cnt = squash_r;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Self-checking bench for cond_flag_unit: directed scenarios plus randomized
// traffic, checked every cycle against a behavioural model.
module tb_cond_flag_unit;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       Cond = 4'h0;
  logic [3:0]       ALUFlags = 4'h0;
  logic [1:0]       FlagW = 2'b00;
  logic             PCS = 1'b0;
  logic             RegW = 1'b0;
  logic             MemW = 1'b0;
  logic             NoWrite = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             PCSrc;
  logic             RegWrite;
  logic             MemWrite;
  logic             CondEx;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] squash_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  cond_flag_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
    .MemW(MemW), .NoWrite(NoWrite), .out_valid(out_valid), .out_ready(out_ready),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
    .Flags(Flags), .squash_cnt(squash_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit cond_true(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cf && !z;
      4'h9: return !cf || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  bit       m_ov = 0, m_ce = 0, m_pc = 0, m_rw = 0, m_mw = 0;
  bit [3:0] m_flags = 4'b0000;
  int       m_cnt = 0;

  always @(posedge clk or negedge reset_n) begin
    bit acc, ce;
    bit [3:0] mask;
    if (!reset_n) begin
      m_ov = 0; m_ce = 0; m_pc = 0; m_rw = 0; m_mw = 0;
      m_flags = 4'b0000; m_cnt = 0;
    end else begin
      acc = in_valid && (!m_ov || out_ready);
      if (acc) begin
        ce   = cond_true(Cond, m_flags);
        m_ov = 1; m_ce = ce;
        m_pc = PCS && ce;
        m_rw = RegW && ce && !NoWrite;
        m_mw = MemW && ce;
        if (ce) begin
          mask    = {FlagW[1], FlagW[1], FlagW[0], FlagW[0]};
          m_flags = (m_flags & ~mask) | (ALUFlags & mask);
        end else if (m_cnt < CNT_MAX) begin
          m_cnt++;
        end
      end else if (out_ready) begin
        m_ov = 0; m_pc = 0; m_rw = 0; m_mw = 0;
      end
    end
  end

  // Compare process: every falling edge.
  always @(negedge clk) begin
    check("out_valid", int'(out_valid), int'(m_ov));
    check("in_ready", int'(in_ready), int'(!m_ov || out_ready));
    check("Flags", int'(Flags), int'(m_flags));
    check("squash_cnt", int'(squash_cnt), m_cnt);
    check("PCSrc", int'(PCSrc), int'(m_ov && m_pc));
    check("RegWrite", int'(RegWrite), int'(m_ov && m_rw));
    check("MemWrite", int'(MemWrite), int'(m_ov && m_mw));
    if (m_ov) check("CondEx", int'(CondEx), int'(m_ce));
  end

  task automatic drive(input logic v, input logic [3:0] c, input logic [1:0] fw,
                       input logic [3:0] alu, input logic pcs, input logic rw,
                       input logic mw, input logic nw, input logic ordy);
    in_valid = v; Cond = c; FlagW = fw; ALUFlags = alu;
    PCS = pcs; RegW = rw; MemW = mw; NoWrite = nw; out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_flags", int'(Flags), 0);
    check("rst_in_ready", int'(in_ready), 1);
    reset_n = 1'b1;

    // AL with full flag write
    drive(1, 4'hE, 2'b11, 4'b0100, 0, 1, 0, 0, 1); tick();
    check("al_valid", int'(out_valid), 1);
    check("al_regwrite", int'(RegWrite), 1);
    check("al_condex", int'(CondEx), 1);
    check("al_flags", int'(Flags), 4'b0100);

    // EQ taken
    drive(1, 4'h0, 2'b00, 4'b0000, 1, 0, 0, 0, 1); tick();
    check("eq_pcsrc", int'(PCSrc), 1);

    // NE squashed
    drive(1, 4'h1, 2'b11, 4'b1111, 0, 0, 1, 0, 1); tick();
    check("ne_memwrite", int'(MemWrite), 0);
    check("ne_condex", int'(CondEx), 0);
    check("ne_squash", int'(squash_cnt), 1);
    check("ne_flags", int'(Flags), 4'b0100);

    // CMP then LT back-to-back
    drive(1, 4'hE, 2'b11, 4'b1000, 0, 1, 0, 1, 1); tick();
    check("cmp_regwrite", int'(RegWrite), 0);
    check("cmp_flags", int'(Flags), 4'b1000);
    drive(1, 4'hB, 2'b00, 4'b0000, 0, 1, 0, 0, 1); tick();
    check("lt_condex", int'(CondEx), 1);
    check("lt_regwrite", int'(RegWrite), 1);

    // Partial flag writes
    drive(1, 4'hE, 2'b11, 4'b0100, 0, 0, 0, 0, 1); tick();
    drive(1, 4'hE, 2'b10, 4'b0011, 0, 0, 0, 0, 1); tick();
    check("fw10_flags", int'(Flags), 4'b0000);
    drive(1, 4'hE, 2'b01, 4'b1111, 0, 0, 0, 0, 1); tick();
    check("fw01_flags", int'(Flags), 4'b0011);

    // Stall for 3 cycles
    drive(1, 4'hE, 2'b11, 4'b1100, 0, 1, 0, 0, 0);
    repeat (3) begin
      tick();
      check("stall_in_ready", int'(in_ready), 0);
      check("stall_valid", int'(out_valid), 1);
      check("stall_flags", int'(Flags), 4'b0011);
    end
    out_ready = 1'b1; #1;
    check("release_in_ready", int'(in_ready), 1);
    tick();
    check("release_flags", int'(Flags), 4'b1100);

    // Never-condition saturation
    drive(1, 4'hF, 2'b11, 4'b0000, 1, 1, 1, 0, 1);
    repeat (CNT_MAX + 2) begin
      tick();
      check("never_regwrite", int'(RegWrite), 0);
    end
    check("sat_squash", int'(squash_cnt), CNT_MAX);

    // Reset mid-stall, checked before any clock edge
    drive(1, 4'hE, 2'b11, 4'b1010, 0, 1, 0, 0, 0);
    repeat (2) tick();
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", int'(out_valid), 0);
    check("arst_flags", int'(Flags), 0);
    check("arst_squash", int'(squash_cnt), 0);
    tick();
    reset_n = 1'b1;

    // Randomized traffic
    repeat (3000) begin
      drive($urandom_range(0, 3) != 0, 4'($urandom), 2'($urandom), 4'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) != 0);
      tick();
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
